// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO drain/stream path: framing bit offsets,
// framing state encoding and the packet counter width.
package fifo_stream_pkg;

    localparam int PKT_CNT_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_state_e;

    function automatic int sop_bit(input int width);
        return width + 1;
    endfunction

    function automatic int eop_bit(input int width);
        return width;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outbound packet stream and status of the stream reader.
// master = the reader itself, slave = the FIFO/consumer side.
interface fifo_stream_reader_if
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic [WIDTH+1:0]     FIFO_Q;
    logic                 FIFO_EMPTY;
    logic                 FIFO_RD;
    logic                 M_VALID;
    logic                 M_READY;
    logic [WIDTH-1:0]     M_DATA;
    logic                 M_SOP;
    logic                 M_EOP;
    logic                 ERR_CLR;
    logic                 ERR;
    logic [PKT_CNT_W-1:0] PKT_CNT;

    modport master (
        input  FIFO_Q, FIFO_EMPTY, M_READY, ERR_CLR,
        output FIFO_RD, M_VALID, M_DATA, M_SOP, M_EOP, ERR, PKT_CNT
    );

    modport slave (
        output FIFO_Q, FIFO_EMPTY, M_READY, ERR_CLR,
        input  FIFO_RD, M_VALID, M_DATA, M_SOP, M_EOP, ERR, PKT_CNT
    );
endinterface

// File: rtl/fifo_stream_reader_skid2.sv
// 2-entry in-order valid/ready buffer; head is registered, a push reaches the head
// one cycle later. Caller must not push when full without a same-cycle pop.
module stream_skid2 #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         rdy_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o,
    output logic [1:0]   occ_o
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   occ_q, occ_d;
    logic         pop;

    assign vld_o = (occ_q != 2'd0);
    assign dat_o = head_q;
    assign occ_o = occ_q;
    assign pop   = vld_o && rdy_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_dat_i;
                else               tail_d = push_dat_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy holds; the new word lands behind whatever remains.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_dat_i;
                end else begin
                    head_d = push_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the FIFO onto a valid/ready packet stream with framing checks; 2-cycle
// empty-to-valid latency, 1 word/cycle; reads are credit-limited to the 2-entry buffer.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int                   WIDTH        = 16,
    parameter logic [PKT_CNT_W-1:0] PKT_CNT_INIT = '0
) (
    input  logic                CLK,
    input  logic                nRST,
    fifo_stream_reader_if.master bus
);
    localparam int SOP_B = sop_bit(WIDTH);
    localparam int EOP_B = eop_bit(WIDTH);

    logic                 inflight_q;
    frame_state_e         state_q, state_d;
    logic                 err_q, err_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 push, viol, pop, m_vld, fifo_rd;
    logic [1:0]           occ;
    logic [WIDTH+1:0]     head;
    logic [2:0]           lvl;
    logic                 cap_sop, cap_eop;

    assign cap_sop = bus.FIFO_Q[SOP_B];
    assign cap_eop = bus.FIFO_Q[EOP_B];
    assign pop     = m_vld && bus.M_READY;

    // Slots committed after this cycle: buffered + the word already on its way - leaving word.
    assign lvl     = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign fifo_rd = nRST && !bus.FIFO_EMPTY && (lvl < 3'd2);

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        viol    = 1'b0;
        if (inflight_q) begin
            if (state_q == ST_IDLE && !cap_sop) begin
                viol = 1'b1;
            end else begin
                // A stray SOP inside a packet restarts framing but still forwards the word.
                push    = 1'b1;
                viol    = (state_q == ST_IN_PKT) && cap_sop;
                state_d = cap_eop ? ST_IDLE : ST_IN_PKT;
            end
        end
    end

    assign err_d     = viol ? 1'b1 : (bus.ERR_CLR ? 1'b0 : err_q);
    assign pkt_cnt_d = (pop && head[EOP_B]) ? pkt_cnt_q + PKT_CNT_W'(1) : pkt_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            inflight_q <= 1'b0;
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            pkt_cnt_q  <= PKT_CNT_INIT;
        end else begin
            inflight_q <= fifo_rd;
            state_q    <= state_d;
            err_q      <= err_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    stream_skid2 #(.W(WIDTH + 2)) u_skid (
        .clk        (CLK),
        .rst_n      (nRST),
        .push_i     (push),
        .push_dat_i (bus.FIFO_Q),
        .rdy_i      (bus.M_READY),
        .vld_o      (m_vld),
        .dat_o      (head),
        .occ_o      (occ)
    );

    assign bus.FIFO_RD = fifo_rd;
    assign bus.M_VALID = m_vld;
    assign bus.M_DATA  = head[WIDTH-1:0];
    assign bus.M_SOP   = head[SOP_B];
    assign bus.M_EOP   = head[EOP_B];
    assign bus.ERR     = err_q;
    assign bus.PKT_CNT = pkt_cnt_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO source model, per-scenario tasks.
module tb_fifo_stream_reader;
    import fifo_stream_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    fifo_stream_reader_if #(.WIDTH(16)) bus ();
    fifo_stream_reader_if #(.WIDTH(16)) wbus ();

    fifo_stream_reader #(.WIDTH(16)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    fifo_stream_reader #(.WIDTH(16), .PKT_CNT_INIT(16'hFFFE)) u_wrap (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (wbus)
    );

    int checks = 0;
    int errors = 0;
    logic [17:0] fq[$];
    logic [17:0] rx[$];
    logic [17:0] pk[4];
    int w_left = 0;

    function automatic logic [17:0] mk(input logic s, input logic e, input logic [15:0] d);
        return {s, e, d};
    endfunction

    // One clock: FIFO model answers reads seen this cycle, then returns at negedge+1.
    task automatic cyc();
        logic rd, wrd;
        rd  = bus.FIFO_RD;
        wrd = wbus.FIFO_RD;
        @(posedge CLK);
        @(negedge CLK);
        if (rd && fq.size() > 0) bus.FIFO_Q = fq.pop_front();
        if (wrd && w_left > 0) begin
            wbus.FIFO_Q = {2'b11, 16'hC000 + 16'(w_left)};
            w_left--;
        end
        bus.FIFO_EMPTY  = (fq.size() == 0);
        wbus.FIFO_EMPTY = (w_left == 0);
        #1;
    endtask

    task automatic load(input logic [17:0] w);
        fq.push_back(w);
        bus.FIFO_EMPTY = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        fq.delete();
        w_left = 0;
        bus.FIFO_EMPTY  = 1'b1;
        wbus.FIFO_EMPTY = 1'b1;
        bus.ERR_CLR = 1'b0;
        bus.M_READY = 1'b1;
        cyc();
        nRST = 1'b1;
        cyc();
    endtask

    task automatic run_collect(input int n);
        rx.delete();
        bus.M_READY = 1'b1;
        repeat (n) begin
            #1;
            if (bus.M_VALID) rx.push_back({bus.M_SOP, bus.M_EOP, bus.M_DATA});
            cyc();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.FIFO_RD !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b want 0", bus.FIFO_RD); end
        checks++; if (bus.M_VALID !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b want 0", bus.M_VALID); end
        checks++; if ({bus.M_SOP, bus.M_EOP, bus.M_DATA} !== 18'h0) begin errors++; $display("FAIL rst_word: got %h want 0", {bus.M_SOP, bus.M_EOP, bus.M_DATA}); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.ERR); end
        checks++; if (bus.PKT_CNT !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0", bus.PKT_CNT); end
        checks++; if (wbus.PKT_CNT !== 16'hFFFE) begin errors++; $display("FAIL rst_wrap_cnt: got %h want fffe", wbus.PKT_CNT); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_rd, exp_vld;
        int idx;
        exp_rd  = 8'b0000_1111;
        exp_vld = 8'b0011_1100;
        idx = 0;
        do_reset();
        for (int i = 0; i < 4; i++) load(pk[i]);
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (bus.FIFO_RD !== exp_rd[c]) begin errors++; $display("FAIL basic_rd c%0d: got %b want %b", c, bus.FIFO_RD, exp_rd[c]); end
            checks++; if (bus.M_VALID !== exp_vld[c]) begin errors++; $display("FAIL basic_vld c%0d: got %b want %b", c, bus.M_VALID, exp_vld[c]); end
            if (bus.M_VALID && idx < 4) begin
                checks++; if ({bus.M_SOP, bus.M_EOP, bus.M_DATA} !== pk[idx]) begin errors++; $display("FAIL basic_word %0d: got %h want %h", idx, {bus.M_SOP, bus.M_EOP, bus.M_DATA}, pk[idx]); end
                idx++;
            end
            cyc();
        end
        checks++; if (bus.PKT_CNT !== 16'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", bus.PKT_CNT); end
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", bus.ERR); end
    endtask

    task automatic test_stall();
        int r, p, idx, popn;
        logic exp_rd, stalled;
        logic [17:0] held;
        r = 0; p = 0; idx = 0; stalled = 1'b0; held = '0;
        do_reset();
        for (int i = 0; i < 4; i++) load(pk[i]);
        for (int c = 0; c < 20; c++) begin
            bus.M_READY = (c % 2 == 0);
            #1;
            popn   = (bus.M_VALID && bus.M_READY) ? 1 : 0;
            exp_rd = !bus.FIFO_EMPTY && ((r - p - popn) < 2);
            checks++; if (bus.FIFO_RD !== exp_rd) begin errors++; $display("FAIL stall_rd c%0d: got %b want %b", c, bus.FIFO_RD, exp_rd); end
            if (stalled) begin
                checks++; if (!bus.M_VALID || {bus.M_SOP, bus.M_EOP, bus.M_DATA} !== held) begin errors++; $display("FAIL stall_hold c%0d: got %b/%h want 1/%h", c, bus.M_VALID, {bus.M_SOP, bus.M_EOP, bus.M_DATA}, held); end
            end
            if (popn == 1) begin
                checks++; if (idx >= 4 || {bus.M_SOP, bus.M_EOP, bus.M_DATA} !== pk[idx % 4]) begin errors++; $display("FAIL stall_word %0d: got %h", idx, {bus.M_SOP, bus.M_EOP, bus.M_DATA}); end
                idx++;
                p++;
            end
            if (bus.FIFO_RD) r++;
            stalled = bus.M_VALID && !bus.M_READY;
            held = {bus.M_SOP, bus.M_EOP, bus.M_DATA};
            cyc();
        end
        checks++; if (idx !== 4) begin errors++; $display("FAIL stall_count: got %0d words want 4", idx); end
        checks++; if (bus.PKT_CNT !== 16'd1) begin errors++; $display("FAIL stall_cnt: got %0d want 1", bus.PKT_CNT); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_w;
        do_reset();
        for (int i = 0; i < 3; i++) load(mk(1'b1, 1'b1, 16'hAA00 + 16'(i)));
        for (int c = 0; c < 7; c++) begin
            #1;
            checks++; if (bus.M_VALID !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL b2b_vld c%0d: got %b", c, bus.M_VALID); end
            if (bus.M_VALID) begin
                exp_w = mk(1'b1, 1'b1, 16'hAA00 + 16'(c - 2));
                checks++; if ({bus.M_SOP, bus.M_EOP, bus.M_DATA} !== exp_w) begin errors++; $display("FAIL b2b_word c%0d: got %h want %h", c, {bus.M_SOP, bus.M_EOP, bus.M_DATA}, exp_w); end
            end
            cyc();
        end
        checks++; if (bus.PKT_CNT !== 16'd3) begin errors++; $display("FAIL b2b_cnt: got %0d want 3", bus.PKT_CNT); end
    endtask

    task automatic test_bad_sop();
        do_reset();
        load(mk(1'b0, 1'b0, 16'hBAD0));
        load(mk(1'b1, 1'b0, 16'hA001));
        load(mk(1'b0, 1'b1, 16'hA002));
        run_collect(10);
        checks++; if (rx.size() !== 2) begin errors++; $display("FAIL badsop_n: got %0d words want 2", rx.size()); end
        checks++; if (rx.size() < 1 || rx[0] !== mk(1'b1, 1'b0, 16'hA001)) begin errors++; $display("FAIL badsop_w0: first word wrong, got %0d words", rx.size()); end
        checks++; if (rx.size() < 2 || rx[1] !== mk(1'b0, 1'b1, 16'hA002)) begin errors++; $display("FAIL badsop_w1: second word wrong, got %0d words", rx.size()); end
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL badsop_err: got %b want 1", bus.ERR); end
        checks++; if (bus.PKT_CNT !== 16'd1) begin errors++; $display("FAIL badsop_cnt: got %0d want 1", bus.PKT_CNT); end
        bus.ERR_CLR = 1'b1;
        cyc();
        bus.ERR_CLR = 1'b0;
        checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL errclr: got %b want 0", bus.ERR); end
        // Violation captured in the same cycle ERR_CLR is high: set wins.
        load(mk(1'b0, 1'b1, 16'hBAD1));
        cyc();
        bus.ERR_CLR = 1'b1;
        cyc();
        bus.ERR_CLR = 1'b0;
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL errclr_race: got %b want 1", bus.ERR); end
        run_collect(4);
        checks++; if (rx.size() !== 0) begin errors++; $display("FAIL badsop_drop: got %0d words want 0", rx.size()); end
    endtask

    task automatic test_mid_sop();
        do_reset();
        load(mk(1'b1, 1'b0, 16'hB001));
        load(mk(1'b1, 1'b0, 16'hB002));
        load(mk(1'b0, 1'b1, 16'hB003));
        run_collect(10);
        checks++; if (rx.size() !== 3) begin errors++; $display("FAIL midsop_n: got %0d words want 3", rx.size()); end
        checks++; if (rx.size() < 2 || rx[1] !== mk(1'b1, 1'b0, 16'hB002)) begin errors++; $display("FAIL midsop_w1: restart word wrong, got %0d words", rx.size()); end
        checks++; if (rx.size() < 3 || rx[2] !== mk(1'b0, 1'b1, 16'hB003)) begin errors++; $display("FAIL midsop_w2: eop word wrong, got %0d words", rx.size()); end
        checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL midsop_err: got %b want 1", bus.ERR); end
        checks++; if (bus.PKT_CNT !== 16'd1) begin errors++; $display("FAIL midsop_cnt: got %0d want 1", bus.PKT_CNT); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) load(pk[i]);
        bus.M_READY = 1'b0;
        cyc();
        cyc();
        cyc();
        #1;
        checks++; if (bus.M_VALID !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b want 1", bus.M_VALID); end
        nRST = 1'b0;
        fq.delete();
        bus.FIFO_EMPTY = 1'b1;
        bus.M_READY = 1'b1;
        #1;
        checks++; if ({bus.FIFO_RD, bus.M_VALID, bus.M_SOP, bus.M_EOP, bus.M_DATA, bus.ERR, bus.PKT_CNT} !== 37'h0) begin errors++; $display("FAIL rmid_outs: got %h want 0", {bus.FIFO_RD, bus.M_VALID, bus.M_SOP, bus.M_EOP, bus.M_DATA, bus.ERR, bus.PKT_CNT}); end
        cyc();
        nRST = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (bus.M_VALID !== 1'b0 || bus.FIFO_RD !== 1'b0) begin errors++; $display("FAIL rmid_quiet c%0d: vld %b rd %b want 0 0", c, bus.M_VALID, bus.FIFO_RD); end
            cyc();
        end
        load(mk(1'b1, 1'b1, 16'hD00D));
        run_collect(5);
        checks++; if (rx.size() !== 1 || rx[0] !== mk(1'b1, 1'b1, 16'hD00D)) begin errors++; $display("FAIL rmid_refill: got %0d words", rx.size()); end
        checks++; if (bus.PKT_CNT !== 16'd1) begin errors++; $display("FAIL rmid_cnt: got %0d want 1", bus.PKT_CNT); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_c;
        do_reset();
        checks++; if (wbus.PKT_CNT !== 16'hFFFE) begin errors++; $display("FAIL wrap_init: got %h want fffe", wbus.PKT_CNT); end
        w_left = 3;
        wbus.FIFO_EMPTY = 1'b0;
        for (int c = 0; c < 7; c++) begin
            #1;
            exp_c = (c <= 2) ? 16'hFFFE : (c == 3) ? 16'hFFFF : (c == 4) ? 16'h0000 : 16'h0001;
            checks++; if (wbus.PKT_CNT !== exp_c) begin errors++; $display("FAIL wrap_cnt c%0d: got %h want %h", c, wbus.PKT_CNT, exp_c); end
            cyc();
        end
    endtask

    initial begin
        nRST = 1'b0;
        bus.FIFO_Q = '0;  bus.FIFO_EMPTY = 1'b1;  bus.M_READY = 1'b0;  bus.ERR_CLR = 1'b0;
        wbus.FIFO_Q = '0; wbus.FIFO_EMPTY = 1'b1; wbus.M_READY = 1'b1; wbus.ERR_CLR = 1'b0;
        pk[0] = mk(1'b1, 1'b0, 16'h1111);
        pk[1] = mk(1'b0, 1'b0, 16'h2222);
        pk[2] = mk(1'b0, 1'b0, 16'h3333);
        pk[3] = mk(1'b0, 1'b1, 16'h4444);
        @(negedge CLK);
        @(negedge CLK);
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_bad_sop();
        test_mid_sop();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
